test_counter_ctrl: RTL and testbench
====================================

Name: test_counter_ctrl

Overview:
Command sequencer and arbiter in front of the slave-CPLD test counter (16-bit seconds counter, 40 MHz prescaled).
- Two requesters share the counter: req0 is the link-side command decoder, req1 is the local switch/debug logic.
- Grants one command at a time using round-robin.
- Drives the counter's enable and synchronous-clear inputs.
- Runs free-running or timed (count-to-target) measurements and reports completion.

Parameters:
- CNT_W, 16, width of counter value and command argument.
- WDT_CYCLES, 4000, link-loss cycles before abort (100 us @ 40 MHz); used only with TCC_LINK_WDT_EN.

Ports:
- i_clk  in  1  system clock (40 MHz)
- i_res  in  1  synchronous active-high reset
- i_req  in  2  per-requester command request; held until acked
- i_cmd0  in  2  requester 0 command
- i_arg0  in  CNT_W  requester 0 argument (target count for TIMED)
- i_cmd1  in  2  requester 1 command
- i_arg1  in  CNT_W  requester 1 argument
- o_ack  out  2  one-hot accept pulse, 1 cycle
- i_cnt  in  CNT_W  current counter value from the test counter
- i_link_ok  in  1  link-health flag (ignored unless TCC_LINK_WDT_EN)
- o_cnt_en  out  1  counter enable
- o_cnt_res  out  1  counter synchronous clear
- o_busy  out  1  high in RUN or TIMED
- o_done  out  1  1-cycle pulse on timed-run completion
- o_state  out  2  current FSM state
- o_wdt_trip  out  1  sticky watchdog abort flag

Behaviour:
- Single clock; reset is synchronous, active-high.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Target register is 0.
  - RR pointer points at requester 1, so requester 0 wins the first tie.
- i_res mid-run aborts immediately to IDLE with no o_done.
- Command encodings: 0 CLEAR, 1 START, 2 STOP, 3 TIMED.
- FSM states: IDLE=0, CLR=1, RUN=2, TIMED=3.
- o_cnt_en and o_cnt_res are registered state decodes, 1-cycle latency from the accept edge:
  - o_cnt_en = (state==RUN || state==TIMED)
  - o_cnt_res = (state==CLR)
- Accept rules:
  - A command is accepted in any state except CLR.
  - In CLR, requests wait.
  - The ack is combinational in the accept cycle.
  - The requester must drop or replace its request the cycle after the ack.
- Arbitration: if only one request is active, it is granted. If both are active, the requester not granted last wins, and the pointer updates only on accept.
- Transitions on accepted commands:
  - CLEAR: any state -> CLR.
  - CLR -> IDLE after exactly 1 cycle, or -> TIMED if a TIMED command is pending.
  - START: IDLE -> RUN. In RUN or TIMED it is acked with no effect.
  - STOP: RUN/TIMED -> IDLE. In IDLE it is acked with no effect.
  - TIMED with arg!=0: latch the target, go to CLR, then TIMED. Accepted from any non-CLR state and restarts any run.
  - TIMED with arg==0: acked, o_done pulses next cycle, state stays or returns IDLE.
- In TIMED, when i_cnt >= target: next state IDLE and o_done pulses for 1 cycle. The counter may still step once within that cycle.
- Simultaneous events in TIMED:
  - An accepted STOP or CLEAR overrides completion; no o_done.
  - The target compare is full-width unsigned, so wrap-around cannot occur: target <= 2^CNT_W-1.

Optional Feature:
- Macro: TCC_LINK_WDT_EN.
- When defined:
  - A counter counts consecutive cycles with i_link_ok==0 while in RUN or TIMED.
  - It resets on i_link_ok==1 or in any other state.
  - On reaching WDT_CYCLES: state -> IDLE, o_wdt_trip=1 (sticky), no o_done.
  - o_wdt_trip clears only on an accepted CLEAR or on i_res.
- When undefined: i_link_ok is ignored, o_wdt_trip is tied 0, and no counter logic is built.

Decomposition:
- Package test_counter_pkg holds:
  - the command encodings (TCC_CMD_CLEAR/START/STOP/TIMED),
  - the state encodings,
  - the default CNT_W.
- Sub-module rr_arb2 is natural: 2-way round-robin arbiter with req[1:0], accept-enable and grant[1:0], holding the pointer internally.

Test Plan:
- Reset, then req0 START -> ack0 same cycle; o_cnt_en=1 next cycle; o_state=2; o_busy=1.
- Both req in the same cycle: req0 STOP, req1 START, first grant -> ack0. Both again -> ack1. Check pointer alternation over 4 ties.
- TIMED arg=3 with a stub counter stepping every 10 cycles:
  - o_cnt_res pulses 1 cycle;
  - o_cnt_en stays high until i_cnt=3;
  - o_done pulses once;
  - o_state returns to 0.
- TIMED arg=0 -> ack, o_done 1 cycle later, o_cnt_en never high.
- RUN, then CLEAR while req1 holds START -> CLR 1 cycle with req1 waiting (no ack), then ack1 in IDLE and RUN resumes. i_res asserted mid-TIMED -> all outputs 0 next cycle, no o_done.
- With TCC_LINK_WDT_EN and WDT_CYCLES=8, in RUN:
  - drop i_link_ok for 7 cycles -> no trip;
  - then 8 cycles -> IDLE, o_wdt_trip=1;
  - a CLEAR clears the flag.

Source files
------------

// File: rtl/test_counter_pkg.sv
// -----------------------------------------------------------------------------
// test_counter_pkg
// Shared definitions for the test-counter command sequencer:
//   - command encodings (TCC_CMD_CLEAR/START/STOP/TIMED)
//   - FSM state encodings (ST_IDLE/ST_CLR/ST_RUN/ST_TIMED)
//   - default counter/argument width
//   - helper to decode "counter running" states
// -----------------------------------------------------------------------------
package test_counter_pkg;

    localparam int TCC_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        TCC_CMD_CLEAR = 2'd0,
        TCC_CMD_START = 2'd1,
        TCC_CMD_STOP  = 2'd2,
        TCC_CMD_TIMED = 2'd3
    } tcc_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLR   = 2'd1,
        ST_RUN   = 2'd2,
        ST_TIMED = 2'd3
    } tcc_state_e;

    // The counter is enabled in both free-running and timed measurement states.
    function automatic logic tcc_is_busy(input tcc_state_e st);
        return (st == ST_RUN) || (st == ST_TIMED);
    endfunction

endpackage

// File: rtl/test_counter_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. On a tie the requester that was not granted
// last wins. The pointer only moves when a grant is actually issued.
// Ports:
//   i_clk        system clock
//   i_res        synchronous active-high reset (pointer -> requester 1,
//                so requester 0 wins the first tie)
//   i_req[1:0]   request vector
//   i_accept_en  grants are only issued while this is high
//   o_grant[1:0] one-hot grant (combinational)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic [1:0] i_req,
    input  logic       i_accept_en,
    output logic [1:0] o_grant
);

    logic       last_q;   // index of the requester granted most recently
    logic [1:0] req_s;
    logic [1:0] grant_s;

    assign req_s = i_req & {2{i_accept_en}};

    // Grant selection: single request wins outright, tie goes against last_q.
    always_comb begin
        grant_s = 2'b00;
        case (req_s)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = last_q ? 2'b01 : 2'b10;
            default: grant_s = 2'b00;
        endcase
    end

    // Pointer register, updated only on an issued grant.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            last_q <= 1'b1;
        end else if (|grant_s) begin
            last_q <= grant_s[1];
        end else begin
            last_q <= last_q;
        end
    end

    assign o_grant = grant_s;

endmodule

// File: rtl/test_counter_ctrl.sv
// -----------------------------------------------------------------------------
// test_counter_ctrl
// Command sequencer and arbiter in front of the slave-CPLD test counter.
// Two requesters (0: link command decoder, 1: local switch/debug) share the
// counter; one command is accepted per cycle via round-robin. The block drives
// the counter enable/synchronous clear and runs free-running or timed
// (count-to-target) measurements.
//
// Optional feature macro: TCC_LINK_WDT_EN
//   When defined, WDT_CYCLES consecutive cycles of i_link_ok==0 while running
//   abort the run to IDLE and set the sticky o_wdt_trip flag (cleared by an
//   accepted CLEAR or i_res). When undefined, i_link_ok is ignored and
//   o_wdt_trip is tied low.
//
// Ports:
//   i_clk, i_res          clock, synchronous active-high reset
//   i_req[1:0]            per-requester request, held until acked
//   i_cmd0/i_arg0         requester 0 command / argument
//   i_cmd1/i_arg1         requester 1 command / argument
//   o_ack[1:0]            one-hot accept pulse (combinational, 1 cycle)
//   i_cnt                 current counter value
//   i_link_ok             link health (watchdog build only)
//   o_cnt_en, o_cnt_res   counter enable / synchronous clear (registered)
//   o_busy                high in RUN or TIMED
//   o_done                1-cycle pulse on timed-run completion
//   o_state               current FSM state
//   o_wdt_trip            sticky watchdog abort flag
// -----------------------------------------------------------------------------
module test_counter_ctrl
    import test_counter_pkg::*;
#(
    parameter int CNT_W      = TCC_CNT_W_DEF,
    parameter int WDT_CYCLES = 4000
) (
    input  logic             i_clk,
    input  logic             i_res,
    input  logic [1:0]       i_req,
    input  logic [1:0]       i_cmd0,
    input  logic [CNT_W-1:0] i_arg0,
    input  logic [1:0]       i_cmd1,
    input  logic [CNT_W-1:0] i_arg1,
    output logic [1:0]       o_ack,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_link_ok,
    output logic             o_cnt_en,
    output logic             o_cnt_res,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_state,
    output logic             o_wdt_trip
);

    tcc_state_e       state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             pend_q, pend_d;      // CLR must continue into TIMED
    logic             done_d;
    logic             cnt_en_q, cnt_res_q, busy_q, done_q;

    logic [1:0]       grant_s;
    logic             accept_en_s;
    logic             accept_s;
    tcc_cmd_e         cmd_s;
    logic [CNT_W-1:0] arg_s;
    logic             hit_s;
    logic             wdt_fire_s;

    // CLR is a one-cycle pass-through state; requests wait through it.
    assign accept_en_s = (state_q != ST_CLR) && !i_res;

    rr_arb2 u_arb (
        .i_clk       (i_clk),
        .i_res       (i_res),
        .i_req       (i_req),
        .i_accept_en (accept_en_s),
        .o_grant     (grant_s)
    );

    assign accept_s = |grant_s;
    assign cmd_s    = tcc_cmd_e'(grant_s[1] ? i_cmd1 : i_cmd0);
    assign arg_s    = grant_s[1] ? i_arg1 : i_arg0;
    assign o_ack    = grant_s;

    // Full-width unsigned compare: a target can never lie beyond the counter range.
    assign hit_s = (state_q == ST_TIMED) && (i_cnt >= target_q);

    // Next-state logic: accepted STOP/CLEAR/TIMED take priority over completion.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        pend_d   = pend_q;
        done_d   = 1'b0;
        case (state_q)
            ST_CLR: begin
                pend_d = 1'b0;
                if (pend_q) begin
                    state_d = ST_TIMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE, ST_RUN, ST_TIMED: begin
                if (accept_s) begin
                    case (cmd_s)
                        TCC_CMD_CLEAR: begin
                            state_d = ST_CLR;
                            pend_d  = 1'b0;
                        end
                        TCC_CMD_START: begin
                            // START is a no-op while running; completion still applies.
                            if (state_q == ST_IDLE) begin
                                state_d = ST_RUN;
                            end else if (hit_s) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = state_q;
                            end
                        end
                        TCC_CMD_STOP: begin
                            state_d = ST_IDLE;
                        end
                        TCC_CMD_TIMED: begin
                            target_d = arg_s;
                            if (|arg_s) begin
                                state_d = ST_CLR;
                                pend_d  = 1'b1;
                            end else begin
                                // Zero target completes at once without touching the counter.
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                        end
                        default: begin
                            state_d = state_q;
                        end
                    endcase
                end else if (hit_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A watchdog abort overrides everything and never reports completion.
        if (wdt_fire_s) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            pend_d  = pend_d;
        end
    end

    // FSM state plus registered output decodes of the next state.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state_q   <= ST_IDLE;
            target_q  <= {CNT_W{1'b0}};
            pend_q    <= 1'b0;
            cnt_en_q  <= 1'b0;
            cnt_res_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            pend_q    <= pend_d;
            cnt_en_q  <= tcc_is_busy(state_d);
            cnt_res_q <= (state_d == ST_CLR);
            busy_q    <= tcc_is_busy(state_d);
            done_q    <= done_d;
        end
    end

    assign o_cnt_en  = cnt_en_q;
    assign o_cnt_res = cnt_res_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_state   = state_q;

`ifdef TCC_LINK_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             trip_q, trip_d;
    logic             link_low_s;

    assign link_low_s = tcc_is_busy(state_q) && !i_link_ok;
    // Fires on the WDT_CYCLES-th consecutive low cycle.
    assign wdt_fire_s = link_low_s && (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1));

    // Watchdog counter and sticky trip flag next-state.
    always_comb begin
        wdt_cnt_d = {WDT_W{1'b0}};
        trip_d    = trip_q;
        if (link_low_s && !wdt_fire_s) begin
            wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
        end else begin
            wdt_cnt_d = {WDT_W{1'b0}};
        end
        if (wdt_fire_s) begin
            trip_d = 1'b1;
        end else if (accept_s && (cmd_s == TCC_CMD_CLEAR)) begin
            trip_d = 1'b0;
        end else begin
            trip_d = trip_q;
        end
    end

    // Watchdog registers.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            wdt_cnt_q <= {WDT_W{1'b0}};
            trip_q    <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            trip_q    <= trip_d;
        end
    end

    assign o_wdt_trip = trip_q;
`else
    logic unused_wdt_s;

    assign wdt_fire_s   = 1'b0;
    assign o_wdt_trip   = 1'b0;
    assign unused_wdt_s = i_link_ok ^ (WDT_CYCLES == 32'sd0);
`endif

endmodule

// File: tb/tb_test_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_test_counter_ctrl
// Directed stimulus with a cycle-level behavioural model of the sequencer,
// a stub test counter (steps every 10 enabled cycles, optional override),
// a per-cycle compare process and hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_test_counter_ctrl;

    localparam int WDT = 8;
    localparam logic [1:0] C_CLEAR = 2'd0;
    localparam logic [1:0] C_START = 2'd1;
    localparam logic [1:0] C_STOP  = 2'd2;
    localparam logic [1:0] C_TIMED = 2'd3;

    logic        clk = 1'b0;
    logic        i_res = 1'b1;
    logic [1:0]  i_req = 2'b00;
    logic [1:0]  i_cmd0 = 2'd0, i_cmd1 = 2'd0;
    logic [15:0] i_arg0 = 16'd0, i_arg1 = 16'd0;
    logic        i_link_ok = 1'b1;
    logic [15:0] i_cnt;
    logic [1:0]  o_ack;
    logic        o_cnt_en, o_cnt_res, o_busy, o_done, o_wdt_trip;
    logic [1:0]  o_state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    test_counter_ctrl #(.CNT_W(16), .WDT_CYCLES(WDT)) dut (
        .i_clk      (clk),
        .i_res      (i_res),
        .i_req      (i_req),
        .i_cmd0     (i_cmd0),
        .i_arg0     (i_arg0),
        .i_cmd1     (i_cmd1),
        .i_arg1     (i_arg1),
        .o_ack      (o_ack),
        .i_cnt      (i_cnt),
        .i_link_ok  (i_link_ok),
        .o_cnt_en   (o_cnt_en),
        .o_cnt_res  (o_cnt_res),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_state    (o_state),
        .o_wdt_trip (o_wdt_trip)
    );

    // Stub test counter: clears on o_cnt_res, steps once per 10 enabled cycles.
    logic [15:0] stub_cnt = 16'd0;
    int          pre = 0;
    logic        ovr_en = 1'b0;
    logic [15:0] ovr_val = 16'd0;
    always @(posedge clk) begin
        if (o_cnt_res) begin
            stub_cnt <= 16'd0;
            pre      <= 0;
        end else if (o_cnt_en) begin
            if (pre == 9) begin
                pre      <= 0;
                stub_cnt <= stub_cnt + 16'd1;
            end else begin
                pre <= pre + 1;
            end
        end
    end
    assign i_cnt = ovr_en ? ovr_val : stub_cnt;

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 clearing, 2 free run, 3 timed run
    int          m_mode = 0;
    logic [15:0] m_target = 16'd0;
    bit          m_timed_next = 1'b0;
    bit          m_last = 1'b1;
    bit          m_done = 1'b0;
    bit          m_trip = 1'b0;
    int          m_low = 0;
    bit          m_live = 1'b0;

    function automatic logic [1:0] model_ack();
        if (i_res || m_mode == 1) return 2'b00;
        case (i_req)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return m_last ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [1:0]  a;
        logic [1:0]  c;
        logic [15:0] g;
        int          old;
        if (i_res) begin
            m_mode = 0; m_target = 16'd0; m_timed_next = 1'b0; m_last = 1'b1;
            m_done = 1'b0; m_trip = 1'b0; m_low = 0; m_live = 1'b1;
        end else begin
            a = model_ack();
            old = m_mode;
            m_done = 1'b0;
            if (old == 1) begin
                m_mode = m_timed_next ? 3 : 0;
                m_timed_next = 1'b0;
            end else if (a != 2'b00) begin
                m_last = a[1];
                c = a[1] ? i_cmd1 : i_cmd0;
                g = a[1] ? i_arg1 : i_arg0;
                case (c)
                    C_CLEAR: begin m_mode = 1; m_timed_next = 1'b0; m_trip = 1'b0; end
                    C_START: begin
                        if (old == 0) m_mode = 2;
                        else if (old == 3 && i_cnt >= m_target) begin m_mode = 0; m_done = 1'b1; end
                    end
                    C_STOP:  m_mode = 0;
                    default: begin
                        m_target = g;
                        if (g != 16'd0) begin m_mode = 1; m_timed_next = 1'b1; end
                        else begin m_mode = 0; m_done = 1'b1; end
                    end
                endcase
            end else if (old == 3 && i_cnt >= m_target) begin
                m_mode = 0; m_done = 1'b1;
            end
`ifdef TCC_LINK_WDT_EN
            if ((old == 2 || old == 3) && !i_link_ok) m_low = m_low + 1;
            else m_low = 0;
            if (m_low >= WDT) begin
                m_low = 0; m_mode = 0; m_done = 1'b0; m_timed_next = 1'b0; m_trip = 1'b1;
            end
`endif
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin : compare
        logic [1:0] ea;
        logic       erun;
        if (m_live) begin
            ea   = model_ack();
            erun = (m_mode == 2) || (m_mode == 3);
            n_vec = n_vec + 1;
            if (o_ack !== ea || o_state !== m_mode[1:0] || o_cnt_en !== erun ||
                o_busy !== erun || o_cnt_res !== (m_mode == 1) ||
                o_done !== m_done || o_wdt_trip !== m_trip) begin
                n_err = n_err + 1;
                $display("FAIL cycle_check t=%0t got ack=%b st=%0d en=%b res=%b busy=%b done=%b trip=%b exp ack=%b st=%0d en=%b res=%b done=%b trip=%b",
                         $time, o_ack, o_state, o_cnt_en, o_cnt_res, o_busy, o_done, o_wdt_trip,
                         ea, m_mode, erun, (m_mode == 1), m_done, m_trip);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic lit(input string name, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise a request, hold it until acked (bounded), then drop it.
    task automatic issue(input int r, input logic [1:0] cmd, input logic [15:0] arg);
        bit got;
        got = 1'b0;
        if (r == 0) begin i_cmd0 = cmd; i_arg0 = arg; i_req[0] = 1'b1; end
        else        begin i_cmd1 = cmd; i_arg1 = arg; i_req[1] = 1'b1; end
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (o_ack[r]) got = 1'b1;
            tick();
        end
        i_req[r] = 1'b0;
        n_vec = n_vec + 1;
        if (!got) begin
            n_err = n_err + 1;
            $display("FAIL ack_timeout req=%0d got=none exp=ack", r);
        end
    endtask

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

    initial begin : stim
        logic [1:0] tie_exp [4];
        int res_n, done_n;
        bit fin;
        tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01; tie_exp[3] = 2'b10;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        lit("rst_state", int'(o_state), 0);
        lit("rst_en", int'(o_cnt_en), 0);
        lit("rst_busy", int'(o_busy), 0);
        lit("rst_done", int'(o_done), 0);
        lit("rst_trip", int'(o_wdt_trip), 0);
        tick();
        i_res = 1'b0;

        // START from requester 0
        i_cmd0 = C_START; i_req = 2'b01;
        @(negedge clk);
        lit("start_ack", int'(o_ack), 1);
        tick();
        i_req = 2'b00;
        @(negedge clk);
        lit("start_en", int'(o_cnt_en), 1);
        lit("start_state", int'(o_state), 2);
        lit("start_busy", int'(o_busy), 1);
        tick();

        // Reset from RUN, then four ties: STOP (req0) vs START (req1)
        i_res = 1'b1;
        tick();
        i_res = 1'b0;
        i_cmd0 = C_STOP; i_cmd1 = C_START; i_req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            lit("tie_ack", int'(o_ack), int'(tie_exp[t]));
            tick();
        end
        i_req = 2'b00;
        @(negedge clk);
        lit("tie_end_state", int'(o_state), 2);
        tick();
        issue(0, C_STOP, 16'd0);

        // TIMED arg=3 with the stub counter
        issue(0, C_TIMED, 16'd3);
        res_n = 0; done_n = 0; fin = 1'b0;
        for (int k = 0; k < 100 && !fin; k++) begin
            @(negedge clk);
            if (o_cnt_res) res_n++;
            if (o_done) begin
                done_n++;
                lit("timed_done_cnt", int'(i_cnt), 3);
                lit("timed_done_en", int'(o_cnt_en), 0);
                fin = 1'b1;
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (o_done) done_n++;
        end
        lit("timed_res_pulses", res_n, 1);
        lit("timed_done_pulses", done_n, 1);
        lit("timed_end_state", int'(o_state), 0);
        tick();

        // TIMED arg=0: immediate completion, counter never enabled
        issue(0, C_TIMED, 16'd0);
        @(negedge clk);
        lit("t0_done", int'(o_done), 1);
        lit("t0_en", int'(o_cnt_en), 0);
        tick();
        @(negedge clk);
        lit("t0_done_once", int'(o_done), 0);
        lit("t0_en_later", int'(o_cnt_en), 0);
        tick();

        // RUN, CLEAR while requester 1 waits with START
        issue(0, C_START, 16'd0);
        i_cmd0 = C_CLEAR; i_req = 2'b01;
        @(negedge clk);
        lit("clr_ack", int'(o_ack), 1);
        tick();
        i_cmd1 = C_START; i_req = 2'b10;
        @(negedge clk);
        lit("clr_wait_ack", int'(o_ack), 0);
        lit("clr_state", int'(o_state), 1);
        lit("clr_res", int'(o_cnt_res), 1);
        tick();
        @(negedge clk);
        lit("clr_idle_ack", int'(o_ack), 2);
        lit("clr_idle_state", int'(o_state), 0);
        tick();
        i_req = 2'b00;
        @(negedge clk);
        lit("resume_state", int'(o_state), 2);
        tick();

        // Reset in the middle of a timed run
        issue(1, C_TIMED, 16'd5);
        tick();
        @(negedge clk);
        lit("midrst_pre_state", int'(o_state), 3);
        tick();
        i_res = 1'b1;
        tick();
        @(negedge clk);
        lit("midrst_state", int'(o_state), 0);
        lit("midrst_en", int'(o_cnt_en), 0);
        lit("midrst_busy", int'(o_busy), 0);
        lit("midrst_done", int'(o_done), 0);
        tick();
        i_res = 1'b0;
        tick();

        // Link loss while running
        issue(0, C_START, 16'd0);
        i_link_ok = 1'b0;
        repeat (7) tick();
        i_link_ok = 1'b1;
        @(negedge clk);
        lit("wdt7_trip", int'(o_wdt_trip), 0);
        lit("wdt7_state", int'(o_state), 2);
        tick();
        i_link_ok = 1'b0;
        repeat (8) tick();
        @(negedge clk);
`ifdef TCC_LINK_WDT_EN
        lit("wdt8_trip", int'(o_wdt_trip), 1);
        lit("wdt8_state", int'(o_state), 0);
`else
        lit("nowdt_trip", int'(o_wdt_trip), 0);
        lit("nowdt_state", int'(o_state), 2);
`endif
        tick();
        i_link_ok = 1'b1;
        issue(0, C_CLEAR, 16'd0);
        @(negedge clk);
        lit("wdt_clr_trip", int'(o_wdt_trip), 0);
        lit("wdt_clr_state", int'(o_state), 1);
        tick();

        // STOP accepted in the completion cycle suppresses o_done
        issue(0, C_TIMED, 16'd4);
        tick();
        ovr_en = 1'b1; ovr_val = 16'd4;
        i_cmd0 = C_STOP; i_req = 2'b01;
        @(negedge clk);
        lit("ovr_stop_ack", int'(o_ack), 1);
        tick();
        i_req = 2'b00;
        @(negedge clk);
        lit("ovr_stop_done", int'(o_done), 0);
        lit("ovr_stop_state", int'(o_state), 0);
        tick();
        ovr_en = 1'b0;

        // Count above target also completes
        issue(0, C_TIMED, 16'd4);
        tick();
        ovr_en = 1'b1; ovr_val = 16'd9;
        @(negedge clk);
        lit("ge_pre_state", int'(o_state), 3);
        tick();
        @(negedge clk);
        lit("ge_done", int'(o_done), 1);
        lit("ge_state", int'(o_state), 0);
        tick();
        ovr_en = 1'b0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
